// File: rtl/seq_signed_multiplier_if.sv
// Request/response bundle for the sequential signed multiplier.
// The requester drives start and both operands; the multiplier returns
// busy, a one-cycle done pulse and the registered 16-bit product.
interface seq_signed_multiplier_if;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        busy;
    logic        done;
    logic [15:0] result;

    // Requester side: issues operations and observes completion.
    modport master (
        output start,
        output a,
        output b,
        input  busy,
        input  done,
        input  result
    );

    // Multiplier side: accepts operations and reports the product.
    modport slave (
        input  start,
        input  a,
        input  b,
        output busy,
        output done,
        output result
    );
endinterface

// File: rtl/seq_signed_multiplier.sv
// Sequential 8x8 signed multiplier producing a 16-bit two's-complement
// product. Operands are reduced to magnitudes, multiplied by shift-add
// (one partial product per clock) and the magnitude product is negated
// when exactly one operand was negative.

// 8-bit absolute value. The result is read as unsigned, so -128 maps to
// 8'h80 (128) without any saturation.
module seq_signed_abs8 (
    input  logic [7:0] value,
    output logic [7:0] magnitude
);
    logic [7:0] inverted;
    logic [8:0] carry;
    logic [7:0] negated;

    assign inverted = ~value;
    assign carry[0] = 1'b1;

    // Ripple increment of the inverted operand forms -value.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_inc
            assign negated[gi]  = inverted[gi] ^ carry[gi];
            assign carry[gi+1]  = inverted[gi] & carry[gi];
        end
    endgenerate

    assign magnitude = value[7] ? negated : value;
endmodule

// 16-bit two's-complement negation. Negating zero yields zero because the
// increment carry ripples straight out of the top bit and is discarded.
module seq_signed_neg16 (
    input  logic [15:0] value,
    output logic [15:0] negated
);
    logic [16:0] carry;

    assign carry[0] = 1'b1;

    // Invert-and-increment as an explicit ripple chain.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_neg
            assign negated[gi] = ~value[gi] ^ carry[gi];
            assign carry[gi+1] = ~value[gi] & carry[gi];
        end
    endgenerate
endmodule

module seq_signed_multiplier (
    input  logic                         clk,
    input  logic                         rst_n,
    seq_signed_multiplier_if.slave       bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        NEG  = 2'd2
    } state_t;

    state_t      state_reg;
    state_t      state_next;

    logic [15:0] acc_reg;
    logic [15:0] mcand_reg;
    logic [7:0]  mplier_reg;
    logic [2:0]  cnt_reg;
    logic        neg_reg;
    logic [15:0] result_reg;
    logic        busy_reg;
    logic        done_reg;

    logic        load;
    logic        step;
    logic        finish;

    logic [7:0]  mag_a;
    logic [7:0]  mag_b;
    logic [15:0] acc_negated;

    seq_signed_abs8 u_abs_a (
        .value     (bus.a),
        .magnitude (mag_a)
    );

    seq_signed_abs8 u_abs_b (
        .value     (bus.b),
        .magnitude (mag_b)
    );

    seq_signed_neg16 u_neg_acc (
        .value   (acc_reg),
        .negated (acc_negated)
    );

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state decode plus the per-state datapath strobes.
    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                // Eighth partial product is being added on this edge.
                if (cnt_reg == 3'd7) begin
                    state_next = NEG;
                end
            end
            NEG: begin
                finish     = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Shift-add datapath: operand capture on accept, one partial product per RUN edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg    <= 16'h0000;
            mcand_reg  <= 16'h0000;
            mplier_reg <= 8'h00;
            cnt_reg    <= 3'd0;
            neg_reg    <= 1'b0;
        end else if (load) begin
            acc_reg    <= 16'h0000;
            mcand_reg  <= {8'h00, mag_a};
            mplier_reg <= mag_b;
            cnt_reg    <= 3'd0;
            neg_reg    <= bus.a[7] ^ bus.b[7];
        end else if (step) begin
            if (mplier_reg[0]) begin
                acc_reg <= acc_reg + mcand_reg;
            end
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_reg >> 1;
            cnt_reg    <= cnt_reg + 3'd1;
        end
    end

    // Result register: sign applied once the magnitude product is complete.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_reg <= 16'h0000;
        end else if (finish) begin
            result_reg <= neg_reg ? acc_negated : acc_reg;
        end
    end

    // Registered status flags so busy/done carry no combinational input path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_reg <= 1'b0;
            done_reg <= 1'b0;
        end else begin
            busy_reg <= (state_next != IDLE);
            done_reg <= finish;
        end
    end

    assign bus.busy   = busy_reg;
    assign bus.done   = done_reg;
    assign bus.result = result_reg;
endmodule

// File: tb/tb_seq_signed_multiplier.sv
// Self-checking bench for seq_signed_multiplier: directed cases from the
// operation rules plus randomized operands against an integer-product model.
module tb_seq_signed_multiplier;
    logic clk;
    logic rst_n;

    int tests_run;
    int tests_failed;

    seq_signed_multiplier_if bus_if ();

    seq_signed_multiplier dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Guard against a hung run.
    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_value(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Reference: plain signed integer product truncated to 16 bits.
    function automatic logic [15:0] model_product(input logic [7:0] av, input logic [7:0] bv);
        int pa;
        int pb;
        int prod;
        pa   = int'($signed(av));
        pb   = int'($signed(bv));
        prod = pa * pb;
        return prod[15:0];
    endfunction

    // One full multiply from IDLE; operands are scrambled while busy.
    task automatic run_mul(input logic [7:0] av, input logic [7:0] bv, input string tag);
        int  lat;
        int  busy_cycles;
        int  overlap;
        bit  seen;
        logic [15:0] exp_res;
        exp_res = model_product(av, bv);
        @(negedge clk);
        bus_if.a     = av;
        bus_if.b     = bv;
        bus_if.start = 1'b1;
        @(posedge clk);
        #1;
        bus_if.start = 1'b0;
        lat = 0;
        busy_cycles = 0;
        overlap = 0;
        seen = 1'b0;
        while (!seen && lat < 20) begin
            bus_if.a = 8'($urandom);
            bus_if.b = 8'($urandom);
            if (bus_if.busy) busy_cycles++;
            if (bus_if.busy && bus_if.done) overlap++;
            if (bus_if.done) begin
                seen = 1'b1;
            end else begin
                @(posedge clk);
                #1;
                lat++;
            end
        end
        check_value({tag, "_done_seen"}, 32'(seen), 32'd1);
        check_value({tag, "_latency"}, 32'(lat), 32'd9);
        check_value({tag, "_busy_cycles"}, 32'(busy_cycles), 32'd9);
        check_value({tag, "_busy_done_overlap"}, 32'(overlap), 32'd0);
        check_value({tag, "_result"}, 32'(bus_if.result), 32'(exp_res));
        @(posedge clk);
        #1;
        check_value({tag, "_done_one_cycle"}, 32'(bus_if.done), 32'd0);
        check_value({tag, "_result_hold"}, 32'(bus_if.result), 32'(exp_res));
        $display("[TB] %s a=%0d b=%0d result=%04h expected=%04h", tag,
                 $signed(av), $signed(bv), bus_if.result, exp_res);
    endtask

    initial begin
        int done_count;
        int k;
        tests_run    = 0;
        tests_failed = 0;
        bus_if.start = 1'b0;
        bus_if.a     = 8'h00;
        bus_if.b     = 8'h00;
        rst_n        = 1'b0;
        #12;
        check_value("reset_busy", 32'(bus_if.busy), 32'd0);
        check_value("reset_done", 32'(bus_if.done), 32'd0);
        check_value("reset_result", 32'(bus_if.result), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases.
        run_mul(8'd7, 8'd6, "pos_7x6");
        check_value("pos_7x6_value", 32'(bus_if.result), 32'h002A);
        run_mul(8'hFD, 8'd5, "neg3x5");
        check_value("neg3x5_value", 32'(bus_if.result), 32'hFFF1);
        run_mul(8'h80, 8'd127, "m128x127");
        check_value("m128x127_value", 32'(bus_if.result), 32'hC080);
        run_mul(8'h80, 8'h80, "m128xm128");
        check_value("m128xm128_value", 32'(bus_if.result), 32'h4000);
        run_mul(8'd0, 8'hFB, "zero_x_neg5");
        check_value("zero_x_neg5_value", 32'(bus_if.result), 32'h0000);

        // Start while busy is ignored.
        @(negedge clk);
        bus_if.a = 8'd2; bus_if.b = 8'd3; bus_if.start = 1'b1;
        @(posedge clk); #1;
        bus_if.start = 1'b0;
        done_count = 0;
        for (k = 1; k <= 15; k++) begin
            @(posedge clk); #1;
            if (bus_if.done) done_count++;
            bus_if.a = 8'($urandom);
            bus_if.b = 8'($urandom);
            bus_if.start = (k == 2) ? 1'b1 : 1'b0;
        end
        check_value("busy_start_done_count", 32'(done_count), 32'd1);
        check_value("busy_start_result", 32'(bus_if.result), 32'h0006);
        check_value("busy_start_idle", 32'(bus_if.busy), 32'd0);
        $display("[TB] start_while_busy dones=%0d result=%04h", done_count, bus_if.result);

        // Back-to-back with start held high.
        @(negedge clk);
        bus_if.a = 8'hFF; bus_if.b = 8'hFF; bus_if.start = 1'b1;
        @(posedge clk); #1;
        done_count = 0;
        for (k = 1; k <= 22; k++) begin
            @(posedge clk); #1;
            if (bus_if.done) done_count++;
            if (k == 9) begin
                check_value("b2b_first_done", 32'(bus_if.done), 32'd1);
                check_value("b2b_first_result", 32'(bus_if.result), 32'h0001);
                bus_if.a = 8'd10; bus_if.b = 8'hF6;
            end
            if (k == 10) begin
                check_value("b2b_first_done_low", 32'(bus_if.done), 32'd0);
                check_value("b2b_second_accepted", 32'(bus_if.busy), 32'd1);
                bus_if.start = 1'b0;
            end
            if (k == 19) begin
                check_value("b2b_second_done", 32'(bus_if.done), 32'd1);
                check_value("b2b_second_result", 32'(bus_if.result), 32'hFF9C);
            end
        end
        check_value("b2b_done_count", 32'(done_count), 32'd2);
        $display("[TB] back_to_back dones=%0d result=%04h", done_count, bus_if.result);

        // Asynchronous reset mid-RUN.
        @(negedge clk);
        bus_if.a = 8'd7; bus_if.b = 8'd6; bus_if.start = 1'b1;
        @(posedge clk); #1;
        bus_if.start = 1'b0;
        for (k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_value("async_rst_busy", 32'(bus_if.busy), 32'd0);
        check_value("async_rst_done", 32'(bus_if.done), 32'd0);
        check_value("async_rst_result", 32'(bus_if.result), 32'd0);
        #4;
        rst_n = 1'b1;
        done_count = 0;
        for (k = 0; k < 15; k++) begin
            @(posedge clk); #1;
            if (bus_if.done) done_count++;
        end
        check_value("async_rst_no_done", 32'(done_count), 32'd0);
        $display("[TB] async_reset dones_after=%0d", done_count);
        run_mul(8'd7, 8'd6, "post_reset_7x6");
        check_value("post_reset_value", 32'(bus_if.result), 32'h002A);

        // Randomized operands, with corner values mixed in.
        for (int i = 0; i < 40; i++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            ra = 8'($urandom);
            rb = 8'($urandom);
            if (i % 8 == 0) ra = 8'h80;
            if (i % 8 == 1) rb = 8'h00;
            if (i % 8 == 2) rb = 8'hFF;
            if (i % 8 == 3) ra = 8'h7F;
            run_mul(ra, rb, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
